// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: 4-way round-robin arbiter with bounded hold; ports clk, rst, req[3:0] -> gnt[3:0] one-hot, gnt_idx[1:0], gnt_valid, preempt
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       preempt
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  state_t state_q, state_d;
  logic [3:0] gnt_q, gnt_d, others;
  logic [1:0] idx_q, idx_d, ptr_q, ptr_d, new_idx;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic pre_q, pre_d, take;
  function automatic logic [1:0] pick(input logic [1:0] s, input logic [3:0] m);
    pick = s;
    for (int i = 3; i >= 0; i--) if (m[s + 2'(i)]) pick = s + 2'(i);
  endfunction
  assign others = req & ~(4'b0001 << idx_q);
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    pre_d = 1'b0;
    take = 1'b0;
    new_idx = 2'd0;
    if (state_q == IDLE) begin
      take = |req;
      new_idx = pick(ptr_q, req);
    end else if (!req[idx_q]) begin
      take = |others;
      new_idx = pick(idx_q + 2'd1, others);
      if (!take) begin
        state_d = IDLE;
        idx_d = 2'd0;
        cnt_d = '0;
      end
    end else if (cnt_q == HOLD_MAX && |others) begin
      take = 1'b1;
      new_idx = pick(idx_q + 2'd1, others);
      pre_d = 1'b1;
    end else begin
      cnt_d = cnt_q == HOLD_MAX ? cnt_q : cnt_q + 1'b1;
    end
    if (take) begin
      state_d = GRANT;
      idx_d = new_idx;
      cnt_d = CNT_W'(1);
      ptr_d = new_idx + 2'd1;
    end
    gnt_d = state_d == GRANT ? 4'b0001 << idx_d : 4'b0000;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q <= '0;
      idx_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      pre_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      idx_q <= idx_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      pre_q <= pre_d;
    end
  end
  assign gnt = gnt_q;
  assign gnt_idx = idx_q;
  assign gnt_valid = |gnt_q;
  assign preempt = pre_q;
endmodule

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
- Round-robin arbiter that shares one 4-input resource between four requesters.
- Outputs a one-hot grant, a binary 2-bit grant index and a grant-valid flag, so downstream muxes can steer directly without a separate encoder.
- Grant is held while the owner keeps requesting, with a bounded hold time so no requester is starved.
- Sits in front of any shared datapath that currently takes a one-hot select.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one owner keeps the grant while others are waiting; legal range 1..15.
- CNT_W, 4, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- req  input  4  request lines, bit i = requester i, level-sensitive.
- gnt  output  4  one-hot grant, registered; all-zero when no owner.
- gnt_idx  output  2  binary index of current owner, registered; 0 when no owner.
- gnt_valid  output  1  high when gnt is non-zero.
- preempt  output  1  one-cycle pulse, asserted in the first cycle of a grant that was forced by hold expiry.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, gnt=0000, gnt_idx=00, gnt_valid=0, preempt=0, ptr=0, cnt=0. Reset overrides any grant in progress; the owner loses grant on the next cycle.
- All outputs are registered. Latency is 1 cycle: a request seen at edge N gives gnt at edge N+1.
- Internal state: owner index, 2-bit pointer ptr, hold counter cnt.
- Selection function pick(start, mask):
  - Search indices start, start+1, ... mod 4.
  - Return the first i with mask[i]=1.
- States:
  - IDLE: gnt=0.
    - If req != 0, grant pick(ptr, req), cnt<=1, go to GRANT.
    - Else stay in IDLE.
  - GRANT: owner = gnt_idx. The conditions below are evaluated each edge, in priority order.
    1. req[owner]=0 (release):
       - If other requests exist, grant pick(owner+1, req), cnt<=1, preempt<=0, stay in GRANT.
       - Else gnt<=0, go to IDLE. No bubble is inserted on a back-to-back handoff.
    2. req[owner]=1, cnt==MAX_HOLD and (req & ~onehot(owner)) != 0 (forced handoff):
       - Grant pick(owner+1, req & ~onehot(owner)), cnt<=1, preempt<=1.
    3. Otherwise:
       - Keep owner, cnt<=min(cnt+1, MAX_HOLD), preempt<=0.
       - With no competitors the owner holds indefinitely and cnt saturates.
- On every new grant to index k, ptr<=k+1 mod 4.
- An owner whose request stays high with competitors present holds for exactly MAX_HOLD cycles.
- MAX_HOLD=1 gives strict per-cycle rotation among active requesters.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt_idx equals the encoding of gnt.
  - gnt_valid = |gnt.
  - preempt implies gnt_valid.
- req changes are sampled only at clock edges; glitches between edges are ignored.

Test Plan:
- Reset then req=0010 held → one cycle later gnt=0010, gnt_idx=01, gnt_valid=1; held indefinitely; preempt stays 0.
- req=1111 from IDLE with ptr=0, each owner dropping req after 2 cycles of grant → grant order 0,1,2,3,0 with no idle cycles between grants; gnt_idx sequence 00,01,10,11,00.
- MAX_HOLD=8, req=0011 held constantly → requester 0 granted 8 cycles, then requester 1 for 8 cycles with preempt=1 in its first cycle, then back to 0; pattern repeats.
- Owner 2 releases while req=1001 → next grant goes to 3 (search from 3), not 0; then ptr=0.
- rst asserted mid-grant (gnt=0100) → next cycle all outputs 0; after rst drops with req=0100, grant is re-issued one cycle later (ptr reset to 0, so pick from 0 yields 2).
- All requests drop while granted → gnt=0000, gnt_valid=0 next cycle; a new req=1000 afterwards gives gnt=1000 one cycle later.
